// File: rtl/first_stage_element_feeder_pkg.sv
// Shared definitions for the first-stage element stream: feeder state encoding
// and the element/layer widths also used by the quadrant accumulator.
package first_stage_element_feeder_pkg;

    localparam int ELEM_W  = 16;
    localparam int LAYER_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/first_stage_element_feeder_counter.sv
// Element index / layer counter for the feeder: wraps index at the vector end,
// bumps the layer, and flags the final element of the final layer.
module element_issue_counter
    import first_stage_element_feeder_pkg::*;
#(
    parameter int VECTOR_LENGTH = 16,
    parameter int NUM_LAYERS    = 4,
    parameter int ADDR_WIDTH    = 4
) (
    input  logic                  i_clock,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic                  i_advance,
    output logic [ADDR_WIDTH-1:0] o_index,
    output logic [LAYER_W-1:0]    o_layer,
    output logic                  o_last_index,
    output logic                  o_last_all
);

    localparam logic [ADDR_WIDTH-1:0] LP_LAST_INDEX = ADDR_WIDTH'(VECTOR_LENGTH - 1);
    localparam logic [LAYER_W-1:0]    LP_LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

    logic [ADDR_WIDTH-1:0] r_index;
    logic [LAYER_W-1:0]    r_layer;
    logic                  w_last_index;
    logic                  w_last_all;

    assign w_last_index = (r_index == LP_LAST_INDEX);
    assign w_last_all   = w_last_index && (r_layer == LP_LAST_LAYER);

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // so ordering between always_ff blocks cannot change the result.
    always_ff @(posedge i_clock) begin
        if (i_clear || i_load) begin
            r_index <= '0;
            r_layer <= '0;
        end else if (i_advance) begin
            if (w_last_index) begin
                r_index <= '0;
                r_layer <= w_last_all ? '0 : r_layer + 1'b1;
            end else begin
                r_index <= r_index + 1'b1;
            end
        end
    end

    assign o_index      = r_index;
    assign o_layer      = r_layer;
    assign o_last_index = w_last_index;
    assign o_last_all   = w_last_all;

endmodule

// File: rtl/first_stage_element_feeder.sv
// Feeder top: start/issue/drain FSM, pause gating with the layer-seam override,
// and the registered element stage driving the quadrant accumulator.
module first_stage_element_feeder
    import first_stage_element_feeder_pkg::*;
#(
    parameter int VECTOR_LENGTH = 16,
    parameter int NUM_LAYERS    = 4,
    parameter int ADDR_WIDTH    = 4
) (
    input  logic                  i_clock,
    input  logic                  i_clear,
    input  logic                  i_start,
    input  logic                  i_pause,
    input  logic [1:0]            i_quadrant_sel,
    input  logic [ELEM_W-1:0]     i_mem_b0,
    input  logic [ELEM_W-1:0]     i_mem_b1,
    input  logic [ELEM_W-1:0]     i_mem_b2,
    input  logic [ELEM_W-1:0]     i_mem_b3,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_read,
    output logic                  o_go,
    output logic [1:0]            o_quadrant,
    output logic [ELEM_W-1:0]     o_b0_element,
    output logic [ELEM_W-1:0]     o_b1_element,
    output logic [ELEM_W-1:0]     o_b2_element,
    output logic [ELEM_W-1:0]     o_b3_element,
    output logic                  o_b_element_ready,
    output logic                  o_last_element,
    output logic                  o_busy,
    output logic                  o_done
);

    feeder_state_e         r_state;
    feeder_state_e         w_next_state;
    logic                  r_go;
    logic [1:0]            r_quadrant;
    logic                  r_busy;
    logic                  r_done_arm;
    logic                  r_done;
    logic                  r_ready;
    logic                  r_last;
    logic [ELEM_W-1:0]     r_b0;
    logic [ELEM_W-1:0]     r_b1;
    logic [ELEM_W-1:0]     r_b2;
    logic [ELEM_W-1:0]     r_b3;

    logic [ADDR_WIDTH-1:0] w_index;
    logic [LAYER_W-1:0]    w_layer;
    logic                  w_last_index;
    logic                  w_last_all;
    logic                  w_start_accept;
    logic                  w_seam;
    logic                  w_issue;

    element_issue_counter #(
        .VECTOR_LENGTH(VECTOR_LENGTH),
        .NUM_LAYERS   (NUM_LAYERS),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_counter (
        .i_clock     (i_clock),
        .i_clear     (i_clear),
        .i_load      (w_start_accept),
        .i_advance   (w_issue),
        .o_index     (w_index),
        .o_layer     (w_layer),
        .o_last_index(w_last_index),
        .o_last_all  (w_last_all)
    );

    // busy stays high through the settle cycle after drain, so start is refused there
    assign w_start_accept = (r_state == ST_IDLE) && !r_busy && i_start;
    // The accumulator loads the first element of layers 1.. without a ready check
    assign w_seam  = (w_index == '0) && (w_layer != '0);
    assign w_issue = (r_state == ST_ISSUE) && (!i_pause || w_seam);

    // NOTE: next state defaults to the current state before the case, so no
    // path through this block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_start_accept)          w_next_state = ST_ISSUE;
            ST_ISSUE: if (w_issue && w_last_all)   w_next_state = ST_DRAIN;
            ST_DRAIN:                              w_next_state = ST_IDLE;
            default:                               w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_state    <= ST_IDLE;
            r_go       <= 1'b0;
            r_quadrant <= '0;
            r_busy     <= 1'b0;
            r_done_arm <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b0;
            r_last     <= 1'b0;
            // NOTE: the element data registers are reset too, because clear
            // must drive every output to zero, not just the control strobes.
            r_b0       <= '0;
            r_b1       <= '0;
            r_b2       <= '0;
            r_b3       <= '0;
        end else begin
            r_state    <= w_next_state;
            r_go       <= w_start_accept;
            if (w_start_accept) begin
                r_quadrant <= i_quadrant_sel;
                r_busy     <= 1'b1;
            end else if (r_done_arm) begin
                r_busy     <= 1'b0;
            end
            // done trails the drain cycle by one settle cycle
            r_done_arm <= (r_state == ST_DRAIN);
            r_done     <= r_done_arm;
            r_ready    <= w_issue;
            r_last     <= w_issue && w_last_index;
            if (w_issue) begin
                r_b0 <= i_mem_b0;
                r_b1 <= i_mem_b1;
                r_b2 <= i_mem_b2;
                r_b3 <= i_mem_b3;
            end
        end
    end

    assign o_mem_addr        = w_index;
    assign o_mem_read        = w_issue;
    assign o_go              = r_go;
    assign o_quadrant        = r_quadrant;
    assign o_b0_element      = r_b0;
    assign o_b1_element      = r_b1;
    assign o_b2_element      = r_b2;
    assign o_b3_element      = r_b3;
    assign o_b_element_ready = r_ready;
    assign o_last_element    = r_last;
    assign o_busy            = r_busy;
    assign o_done            = r_done;

endmodule

// File: tb/tb_first_stage_element_feeder.sv
// Bench for first_stage_element_feeder: directed runs with randomized pause and
// bank data, compared each cycle against a beat-level model of the stream.
module tb_first_stage_element_feeder;

    localparam int VL    = 16;
    localparam int NL    = 4;
    localparam int AW    = 4;
    localparam int BEATS = VL * NL;

    logic          clock = 1'b0;
    logic          clear;
    logic          start;
    logic          pause;
    logic [1:0]    qsel;
    logic [15:0]   mb0, mb1, mb2, mb3;
    logic [AW-1:0] mem_addr;
    logic          mem_read, go, ready, last_el, busy, done;
    logic [1:0]    quadrant;
    logic [15:0]   b0e, b1e, b2e, b3e;
    logic [15:0]   salt;

    int n_compared   = 0;
    int n_mismatched = 0;

    // model of the stream, in terms of beats issued so far
    bit          m_go, m_active, m_busy, m_ready, m_last;
    int          m_pos, m_done_in;
    logic [1:0]  m_quad;
    logic [15:0] m_data [4];
    int          beats, lasts, dones;

    always #5 clock = ~clock;

    // banks answer asynchronously: word = salt + addr + 16*bank
    assign mb0 = salt + 16'(mem_addr);
    assign mb1 = salt + 16'(mem_addr) + 16'd16;
    assign mb2 = salt + 16'(mem_addr) + 16'd32;
    assign mb3 = salt + 16'(mem_addr) + 16'd48;

    first_stage_element_feeder #(
        .VECTOR_LENGTH(VL), .NUM_LAYERS(NL), .ADDR_WIDTH(AW)
    ) dut (
        .i_clock(clock), .i_clear(clear), .i_start(start), .i_pause(pause),
        .i_quadrant_sel(qsel),
        .i_mem_b0(mb0), .i_mem_b1(mb1), .i_mem_b2(mb2), .i_mem_b3(mb3),
        .o_mem_addr(mem_addr), .o_mem_read(mem_read), .o_go(go), .o_quadrant(quadrant),
        .o_b0_element(b0e), .o_b1_element(b1e), .o_b2_element(b2e), .o_b3_element(b3e),
        .o_b_element_ready(ready), .o_last_element(last_el), .o_busy(busy), .o_done(done)
    );

    function automatic logic [15:0] bank_word(input int addr, input int b);
        return 16'(salt + 16'(addr) + 16'(16 * b));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_go = 0; m_active = 0; m_busy = 0; m_ready = 0; m_last = 0;
        m_pos = 0; m_done_in = 0; m_quad = '0;
        for (int b = 0; b < 4; b++) m_data[b] = '0;
    endtask

    // one clock cycle: drive, compare at negedge, advance model over the edge
    task automatic cycle(input bit st, input bit ps, input bit cl);
        bit exp_issue, exp_busy, exp_done, accept;
        clear = cl; start = st; pause = ps;
        @(negedge clock);
        exp_issue = m_active && (!ps || ((m_pos % VL) == 0 && m_pos != 0));
        exp_busy  = m_busy && (m_done_in != 1);
        exp_done  = (m_done_in == 1);
        check("go", 32'(go), 32'(m_go));
        check("mem_read", 32'(mem_read), 32'(exp_issue));
        if (exp_issue) check("mem_addr", 32'(mem_addr), 32'(m_pos % VL));
        check("ready", 32'(ready), 32'(m_ready));
        check("last_element", 32'(last_el), 32'(m_last));
        check("b0_element", 32'(b0e), 32'(m_data[0]));
        check("b1_element", 32'(b1e), 32'(m_data[1]));
        check("b2_element", 32'(b2e), 32'(m_data[2]));
        check("b3_element", 32'(b3e), 32'(m_data[3]));
        check("busy", 32'(busy), 32'(exp_busy));
        check("done", 32'(done), 32'(exp_done));
        check("quadrant", 32'(quadrant), 32'(m_quad));
        if (ready)   beats++;
        if (last_el) lasts++;
        if (done)    dones++;
        @(posedge clock);
        if (cl) begin
            model_reset();
        end else begin
            accept = st && !exp_busy;
            if (m_done_in > 0) m_done_in--;
            if (exp_done) m_busy = 0;
            m_ready = exp_issue;
            m_last  = exp_issue && ((m_pos % VL) == VL - 1);
            if (exp_issue) begin
                for (int b = 0; b < 4; b++) m_data[b] = bank_word(m_pos % VL, b);
                m_pos++;
                if (m_pos == BEATS) begin
                    m_active  = 0;
                    m_done_in = 3;
                end
            end
            m_go = accept;
            if (accept) begin
                m_busy = 1; m_quad = qsel; m_pos = 0; m_active = 1;
            end
        end
        #1;
    endtask

    // mode 0: no pause, 1: random pause, 2: toggle, 3: long hold after layer 0,
    // 4: no pause with stray start pulses
    task automatic run_to_done(input int mode);
        int budget = 600;
        int held   = 0;
        bit p      = 0;
        bit st;
        while (m_busy && budget > 0) begin
            st = 0;
            case (mode)
                1: p = bit'($urandom_range(0, 1));
                2: p = ~p;
                3: begin
                    p = (m_pos >= VL) && (held < 20);
                    if (p) held++;
                end
                4: begin
                    p  = 0;
                    st = m_active && ($urandom_range(0, 7) == 0);
                end
                default: p = 0;
            endcase
            cycle(st, p, 0);
            budget--;
        end
        if (budget == 0) begin
            n_compared++;
            n_mismatched++;
            $error("FAIL run_timeout observed=busy expected=idle");
        end
    endtask

    task automatic begin_run(input logic [1:0] q, input logic [15:0] s);
        qsel = q; salt = s;
        beats = 0; lasts = 0; dones = 0;
        cycle(1, 0, 0);
    endtask

    task automatic check_run_totals(input string tag);
        check({tag, "_beats"}, 32'(beats), 32'(BEATS));
        check({tag, "_lasts"}, 32'(lasts), 32'(NL));
        check({tag, "_dones"}, 32'(dones), 32'(1));
    endtask

    initial begin
        salt = '0; qsel = '0;
        model_reset();

        // reset with start held: all zero, no go once released
        cycle(1, 0, 1);
        cycle(1, 0, 1);
        cycle(0, 0, 0);
        cycle(0, 0, 0);

        // plain run, quadrant 2, banks addr+16*bank; done exactly 66 after go
        begin_run(2'd2, 16'd0);
        run_to_done(0);
        check_run_totals("plain");
        cycle(0, 0, 0);

        // random pause with random data
        begin_run(2'(($urandom_range(0, 3))), 16'($urandom));
        run_to_done(1);
        check_run_totals("random_pause");

        // pause toggling every other cycle
        begin_run(2'd1, 16'($urandom));
        run_to_done(2);
        check_run_totals("toggle_pause");

        // pause held across the first seam: seam issue still happens
        begin_run(2'd3, 16'($urandom));
        run_to_done(3);
        check_run_totals("held_pause");

        // clear at beat 20, then a fresh run starts at index 0 layer 0
        begin_run(2'd2, 16'($urandom));
        for (int i = 0; i < 200 && beats < 20; i++) cycle(0, 0, 0);
        cycle(0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0);
        check("abort_no_done", 32'(dones), 32'(0));
        begin_run(2'd0, 16'($urandom));
        run_to_done(1);
        check_run_totals("after_abort");

        // stray start pulses while busy are ignored
        begin_run(2'd1, 16'($urandom));
        run_to_done(4);
        check_run_totals("start_while_busy");
        cycle(0, 0, 0);
        cycle(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
